// File: rtl/wb_stage_pkg.sv
// Shared MIPS decode constants and load-extension helper for the writeback stage.
package mips_defs;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int NUM_RD = 2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [REG_W-1:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_src_e;

  // Little-endian lane pick; halfword ignores addr[0] since misalignment traps earlier.
  function automatic logic [DATA_W-1:0] load_ext(input logic [5:0] op,
                                                 input logic [DATA_W-1:0] dr,
                                                 input logic [1:0] addr);
    logic [7:0]  b;
    logic [15:0] h;
    b = dr[{addr, 3'b000} +: 8];
    h = addr[1] ? dr[31:16] : dr[15:0];
    case (op)
      OP_LB:   load_ext = {{24{b[7]}}, b};
      OP_LBU:  load_ext = {24'h0, b};
      OP_LH:   load_ext = {{16{h[15]}}, h};
      OP_LHU:  load_ext = {16'h0, h};
      default: load_ext = dr;
    endcase
  endfunction

endpackage

// File: rtl/wb_stage_grf.sv
// 32x32 general register file: async active-low clear, one write port, bypassed read ports.
module grf
  import mips_defs::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          we_i,
  input  logic [REG_W-1:0]              wa_i,
  input  logic [DATA_W-1:0]             wd_i,
  input  logic [NUM_RD-1:0][REG_W-1:0]  ra_i,
  output logic [NUM_RD-1:0][DATA_W-1:0] rd_o
);

  logic [31:0][DATA_W-1:0] regs_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      regs_q <= '0;
    else if (we_i && (wa_i != '0))
      regs_q[wa_i] <= wd_i;
  end

  // Same-cycle writes are forwarded so D never waits on W.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    always_comb begin
      rd_o[p] = '0;
      if (ra_i[p] != '0) begin
        if (we_i && (ra_i[p] == wa_i))
          rd_o[p] = wd_i;
        else
          rd_o[p] = regs_q[ra_i[p]];
      end
    end
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: decode, load extension, write-data select, register file and retire count.
module wb_stage
  import mips_defs::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] IR_W,
  input  logic [DATA_W-1:0] PC4_W,
  input  logic [DATA_W-1:0] AO_W,
  input  logic [DATA_W-1:0] DR_W,
  input  logic [REG_W-1:0]  RA1,
  input  logic [REG_W-1:0]  RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              WE_W,
  output logic [REG_W-1:0]  WA_W,
  output logic [DATA_W-1:0] WD_W,
  output logic [DATA_W-1:0] RETIRED
);

  logic [5:0]       op, fn;
  logic [REG_W-1:0] rs_unused, rt, rd;
  logic             wr;
  logic [REG_W-1:0] dst;
  wb_src_e          src;
  logic [DATA_W-1:0] retired_q, retired_d;
  logic [NUM_RD-1:0][REG_W-1:0]  ra;
  logic [NUM_RD-1:0][DATA_W-1:0] rdat;
  logic             shamt_unused;

  assign op           = IR_W[31:26];
  assign rs_unused    = IR_W[25:21];
  assign rt           = IR_W[20:16];
  assign rd           = IR_W[15:11];
  assign fn           = IR_W[5:0];
  assign shamt_unused = ^IR_W[10:6];

  always_comb begin
    wr  = 1'b0;
    dst = rd;
    src = WB_ALU;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_ADDU || fn == FN_SUBU) wr = 1'b1;
        if (fn == FN_JALR) begin
          wr  = 1'b1;
          src = WB_LINK;
        end
      end
      OP_ORI, OP_LUI: begin
        wr  = 1'b1;
        dst = rt;
      end
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
        wr  = 1'b1;
        dst = rt;
        src = WB_MEM;
      end
      OP_JAL: begin
        wr  = 1'b1;
        dst = REG_RA;
        src = WB_LINK;
      end
      default: ;
    endcase
  end

  assign WE_W = wr && (dst != '0);
  assign WA_W = WE_W ? dst : '0;

  // Link value skips the delay slot.
  always_comb begin
    case (src)
      WB_MEM:  WD_W = load_ext(op, DR_W, AO_W[1:0]);
      WB_LINK: WD_W = PC4_W + 32'd4;
      default: WD_W = AO_W;
    endcase
  end

  assign ra  = {RA2, RA1};
  assign RD1 = rdat[0];
  assign RD2 = rdat[1];

  grf u_grf (
    .clk   (clk),
    .reset (reset),
    .we_i  (WE_W),
    .wa_i  (WA_W),
    .wd_i  (WD_W),
    .ra_i  (ra),
    .rd_o  (rdat)
  );

  assign retired_d = (IR_W != '0) ? retired_q + 32'd1 : retired_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign RETIRED = retired_q;

endmodule
